// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter that shares one single-port BRAM between the loader (0) and the accessor (1).
// The BRAM command is registered, and read data comes back with an id-tagged valid strobe.
module bram_port_arbiter #(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_i,
   input  logic              we0_i,
   input  logic [AWIDTH-1:0] addr0_i,
   input  logic [DWIDTH-1:0] d0_i,
   input  logic              req1_i,
   input  logic              we1_i,
   input  logic [AWIDTH-1:0] addr1_i,
   input  logic [DWIDTH-1:0] d1_i,
   output logic              gnt0_o,
   output logic              gnt1_o,
   output logic              rvalid0_o,
   output logic              rvalid1_o,
   output logic [DWIDTH-1:0] rdata_o,
   output logic [AWIDTH-1:0] addr_o,
   output logic              ce_o,
   output logic              we_o,
   output logic [DWIDTH-1:0] d_o,
   input  logic [DWIDTH-1:0] q_i
);

   generate
      if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
         $error("bram_port_arbiter: RD_LAT must be 1 or 2");
      end
   endgenerate

   typedef enum logic {
      PRIO_R0 = 1'b0,
      PRIO_R1 = 1'b1
   } prio_e;

   prio_e             prio;
   logic              acc0;
   logic              acc1;
   logic              acc;
   logic              acc_we;
   logic [AWIDTH-1:0] acc_addr;
   logic [DWIDTH-1:0] acc_d;

   // Each stage holds {valid, id}; stage 0 lines up with the registered command.
   logic [RD_LAT:0]   pipe_v;
   logic [RD_LAT:0]   pipe_id;

   always_comb begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
      if (!reset) begin
         if (req0_i && (!req1_i || prio == PRIO_R0)) begin
            gnt0_o = 1'b1;
         end else if (req1_i) begin
            gnt1_o = 1'b1;
         end
      end
   end

   always_comb begin
      acc0     = req0_i & gnt0_o;
      acc1     = req1_i & gnt1_o;
      acc      = acc0 | acc1;
      acc_we   = acc1 ? we1_i   : we0_i;
      acc_addr = acc1 ? addr1_i : addr0_i;
      acc_d    = acc1 ? d1_i    : d0_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio <= PRIO_R0;
      end else if (acc0) begin
         prio <= PRIO_R1;
      end else if (acc1) begin
         prio <= PRIO_R0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ce_o   <= 1'b0;
         we_o   <= 1'b0;
         addr_o <= '0;
         d_o    <= '0;
      end else begin
         ce_o <= acc;
         we_o <= acc & acc_we;
         if (acc) begin
            addr_o <= acc_addr;
            d_o    <= acc_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_v  <= '0;
         pipe_id <= '0;
      end else begin
         pipe_v  <= {pipe_v[RD_LAT-1:0], acc & ~acc_we};
         pipe_id <= {pipe_id[RD_LAT-1:0], acc1};
      end
   end

   always_comb begin
      rvalid0_o = pipe_v[RD_LAT] & ~pipe_id[RD_LAT];
      rvalid1_o = pipe_v[RD_LAT] &  pipe_id[RD_LAT];
      rdata_o   = q_i;
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: a BRAM model plus a reference model that feeds a scoreboard queue
// and a monitor that checks every read return against that queue.
module tb_bram_port_arbiter;
   parameter int RD_LAT = 1;
   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk;
   logic          reset;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] d0, d1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata;
   logic [AW-1:0] addr_o;
   logic          ce_o, we_o;
   logic [DW-1:0] d_o;
   logic [DW-1:0] q_i;

   bram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset),
      .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .d0_i(d0),
      .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .d1_i(d1),
      .gnt0_o(gnt0), .gnt1_o(gnt1),
      .rvalid0_o(rvalid0), .rvalid1_o(rvalid1), .rdata_o(rdata),
      .addr_o(addr_o), .ce_o(ce_o), .we_o(we_o), .d_o(d_o), .q_i(q_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] init_val(input int i);
      return 32'hA500_0000 ^ (i * 32'h0101_0107);
   endfunction

   // Write-first BRAM with RD_LAT cycles from command to q.
   logic [DW-1:0] mem [256];
   logic [DW-1:0] qpipe [RD_LAT];
   always @(posedge clk) begin
      if (ce_o === 1'b1 && we_o === 1'b1) mem[addr_o] <= d_o;
      qpipe[0] <= (ce_o === 1'b1 && we_o === 1'b1) ? d_o : mem[addr_o];
      for (int i = 1; i < RD_LAT; i++) qpipe[i] <= qpipe[i-1];
   end
   assign q_i = qpipe[RD_LAT-1];

   // Reference model: a tie goes to whoever was not granted last.
   typedef struct packed {
      logic          id;
      logic [DW-1:0] data;
   } rd_t;
   rd_t           exp_q[$];
   logic [DW-1:0] ref_mem [256];
   int            last_won;
   bit            cmd_known = 0;
   bit            started = 0;
   logic          exp_ce, exp_we;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_d;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = init_val(i);
         ref_mem[i] = init_val(i);
      end
   end

   initial begin
      int w;
      forever begin
         @(negedge clk);
         if (cmd_known) begin
            chk("ce_o", ce_o, exp_ce);
            chk("we_o", we_o, exp_we);
            chk("addr_o", addr_o, exp_addr);
            chk("d_o", d_o, exp_d);
         end
         if (reset) begin
            chk("gnt0_in_reset", gnt0, 0);
            chk("gnt1_in_reset", gnt1, 0);
            last_won  = 1;
            exp_q.delete();
            exp_ce    = 0;
            exp_we    = 0;
            exp_addr  = '0;
            exp_d     = '0;
            cmd_known = 1;
         end else begin
            if (req0 && req1) w = (last_won == 1) ? 0 : 1;
            else if (req0)    w = 0;
            else if (req1)    w = 1;
            else              w = -1;
            chk("gnt0", gnt0, (w == 0));
            chk("gnt1", gnt1, (w == 1));
            if (w < 0) begin
               exp_ce = 0;
               exp_we = 0;
            end else begin
               exp_ce   = 1;
               exp_we   = (w == 0) ? we0 : we1;
               exp_addr = (w == 0) ? addr0 : addr1;
               exp_d    = (w == 0) ? d0 : d1;
               last_won = w;
               if (exp_we) ref_mem[exp_addr] = exp_d;
               else exp_q.push_back('{id: (w == 1), data: ref_mem[exp_addr]});
            end
         end
      end
   end

   // Monitor: every read return must match the oldest outstanding read.
   initial begin
      rd_t e;
      forever begin
         @(negedge clk);
         if (started && !reset) begin
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
               chk("rvalid_exclusive", (rvalid0 === 1'b1 && rvalid1 === 1'b1), 0);
               if (exp_q.size() == 0) begin
                  chk("rvalid_unexpected", {rvalid1, rvalid0}, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rvalid_id", {rvalid1, rvalid0}, e.id ? 2'b10 : 2'b01);
                  chk("rdata", rdata, e.data);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      req0 = 0; req1 = 0;
      repeat (n) step();
   endtask

   initial begin
      bit a0, a1;
      reset = 1; req0 = 0; we0 = 0; addr0 = '0; d0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; d1 = '0;
      repeat (3) step();
      reset = 0;
      started = 1;

      // Contention right after reset: 0,1,0,1,0,1
      req0 = 1; we0 = 0; addr0 = 8'h20;
      req1 = 1; we1 = 0; addr1 = 8'h30;
      repeat (6) step();
      idle(RD_LAT + 3);

      // Single requester reads of 0x00..0x03
      for (int i = 0; i < 4; i++) begin
         req1 = 1; we1 = 0; addr1 = AW'(i);
         step();
      end
      idle(RD_LAT + 3);

      // Write then read-back of the same address on consecutive cycles
      req0 = 1; we0 = 1; addr0 = 8'h10; d0 = 32'hDEAD_BEEF;
      step();
      req0 = 0; req1 = 1; we1 = 0; addr1 = 8'h10;
      step();
      idle(RD_LAT + 3);

      // Idle gap on requester 0: 1,0,1
      req0 = 1; we0 = 0; addr0 = 8'h07; step();
      req0 = 0; step();
      req0 = 1; addr0 = 8'h08; step();
      idle(RD_LAT + 3);

      // Reset in the cycle after an accepted read; next contended grant goes to 0
      req0 = 1; we0 = 0; addr0 = 8'h05; step();
      req0 = 0; reset = 1; step();
      reset = 0;
      idle(RD_LAT + 2);
      req0 = 1; addr0 = 8'h06; req1 = 1; addr1 = 8'h09; step();
      step();
      idle(RD_LAT + 3);

      // Random traffic; a denied request is held until granted
      req0 = 0; req1 = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         a0 = req0 && gnt0;
         a1 = req1 && gnt1;
         @(posedge clk);
         #1;
         reset = ($urandom_range(0, 149) == 0);
         if (!req0 || a0) begin
            req0  = ($urandom_range(0, 99) < 65);
            we0   = ($urandom_range(0, 2) == 0);
            addr0 = AW'($urandom_range(0, 15));
            d0    = $urandom;
         end
         if (!req1 || a1) begin
            req1  = ($urandom_range(0, 99) < 65);
            we1   = ($urandom_range(0, 2) == 0);
            addr1 = AW'($urandom_range(0, 15));
            d1    = $urandom;
         end
      end
      reset = 0;
      idle(RD_LAT + 4);
      chk("drain_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
